// File: rtl/pid_servo_gen_pkg.sv
// Shared constants for the pid_servo_gen servo core: coefficient indices,
// state encodings, default fixed-point format and a generic saturate helper.
package pid_servo_pkg;

  localparam int FRAC_W_DEF = 26;
  localparam int NUM_COEF   = 6;
  localparam int SAT_W      = 64;

  localparam logic [2:0] COEF_A1_PD = 3'd0;
  localparam logic [2:0] COEF_B0_PD = 3'd1;
  localparam logic [2:0] COEF_B1_PD = 3'd2;
  localparam logic [2:0] COEF_A1_PI = 3'd3;
  localparam logic [2:0] COEF_B0_PI = 3'd4;
  localparam logic [2:0] COEF_B1_PI = 3'd5;

  localparam logic [1:0] ST_OFF  = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_HOLD = 2'd2;

  // Clip a wide signed value into the range of a data_w-bit signed word.
  function automatic logic signed [SAT_W-1:0] saturate(input logic signed [SAT_W-1:0] v,
                                                       input int data_w);
    logic signed [SAT_W-1:0] hi;
    logic signed [SAT_W-1:0] lo;
    hi = (64'sd1 <<< (data_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi)      saturate = hi;
    else if (v < lo) saturate = lo;
    else             saturate = v;
  endfunction

endpackage

// File: rtl/pid_servo_gen_iir1_stage.sv
// One registered first-order IIR section y = sat((a1*y' + b0*x + b1*x') >>> FRAC_W)
// with clear/hold control, output clamp window and optional anti-windup.
module iir1_stage
  import pid_servo_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int COEF_W      = 35,
  parameter int FRAC_W      = FRAC_W_DEF,
  parameter int ACC_W       = 56,
  parameter bit ANTI_WINDUP = 1'b0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     clr_i,
  input  logic                     hold_i,
  input  logic signed [COEF_W-1:0] a1_i,
  input  logic signed [COEF_W-1:0] b0_i,
  input  logic signed [COEF_W-1:0] b1_i,
  input  logic signed [DATA_W-1:0] x_i,
  input  logic signed [DATA_W-1:0] lo_i,
  input  logic signed [DATA_W-1:0] hi_i,
  input  logic [1:0]               railed_i,
  output logic signed [DATA_W-1:0] y_o,
  output logic [1:0]               sat_o
);

  logic signed [DATA_W-1:0] x_q, y_q, y_d;
  logic [1:0]               sat_q, sat_d;

  logic signed [ACC_W-1:0]  acc, shifted;
  logic signed [SAT_W-1:0]  wide, sat_v;
  logic signed [DATA_W-1:0] cand, hi_eff;
  logic                     up_stop, dn_stop;

  always_comb begin
    acc = ACC_W'(a1_i) * ACC_W'(y_q) + ACC_W'(b0_i) * ACC_W'(x_i) + ACC_W'(b1_i) * ACC_W'(x_q);
    shifted = acc >>> FRAC_W;
    wide    = SAT_W'(shifted);
    sat_v   = saturate(wide, DATA_W);
    cand    = sat_v[DATA_W-1:0];
    sat_d   = 2'b00;
    if (wide != sat_v) sat_d = wide[SAT_W-1] ? 2'b01 : 2'b10;
    // An inverted window collapses onto its lower bound.
    hi_eff = (lo_i > hi_i) ? lo_i : hi_i;
    if (cand > hi_eff) begin
      cand     = hi_eff;
      sat_d[1] = 1'b1;
    end else if (cand < lo_i) begin
      cand     = lo_i;
      sat_d[0] = 1'b1;
    end
    up_stop = ANTI_WINDUP && (railed_i[1] || sat_q[1]) && (cand > y_q);
    dn_stop = ANTI_WINDUP && (railed_i[0] || sat_q[0]) && (cand < y_q);
    if (up_stop || dn_stop || (ANTI_WINDUP && railed_i == 2'b11)) y_d = y_q;
    else                                                          y_d = cand;
  end

  always_ff @(posedge clk_in) begin
    if (rst_in || clr_i) begin
      x_q   <= '0;
      y_q   <= '0;
      sat_q <= 2'b00;
    end else if (!hold_i) begin
      x_q   <= x_i;
      y_q   <= y_d;
      sat_q <= sat_d;
    end
  end

  assign y_o   = y_q;
  assign sat_o = sat_q;

endmodule

// File: rtl/pid_servo_gen.sv
// PD-into-PI servo core with OFF/RUN/HOLD control and double-buffered coefficients.
// Optional output clamp window enabled by defining PIDSERVO_CLAMP_EN.
module pid_servo_gen
  import pid_servo_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int COEF_W = 35,
  parameter int FRAC_W = FRAC_W_DEF,
  parameter int ACC_W  = 56
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic                     on_in,
  input  logic                     hold_in,
  input  logic [1:0]               railed_in,
  input  logic                     coef_wr_in,
  input  logic [2:0]               coef_sel_in,
  input  logic signed [COEF_W-1:0] coef_data_in,
  input  logic                     coef_commit_in,
  output logic                     coef_busy_out,
  input  logic signed [DATA_W-1:0] e_in,
  output logic signed [DATA_W-1:0] e_out,
  output logic [1:0]               sat_out,
  output logic [1:0]               state_out
`ifdef PIDSERVO_CLAMP_EN
  ,
  input  logic signed [DATA_W-1:0] clamp_hi_in,
  input  logic signed [DATA_W-1:0] clamp_lo_in
`endif
);

  localparam logic signed [DATA_W-1:0] D_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] D_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [1:0] state_q, state_d;
  logic       busy_q;
  logic       write_ok, commit_ok;
  logic [NUM_COEF-1:0] shadow_we;
  logic signed [COEF_W-1:0] shadow_q [NUM_COEF];
  logic signed [COEF_W-1:0] active_q [NUM_COEF];

  logic signed [DATA_W-1:0] pd_y, pi_y, clamp_lo, clamp_hi;
  logic [1:0]               pi_sat;

`ifdef PIDSERVO_CLAMP_EN
  assign clamp_lo = clamp_lo_in;
  assign clamp_hi = clamp_hi_in;
`else
  assign clamp_lo = D_MIN;
  assign clamp_hi = D_MAX;
`endif

  always_comb begin
    state_d = state_q;
    if (!on_in) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:  state_d = ST_RUN;
        ST_RUN:  state_d = hold_in ? ST_HOLD : ST_RUN;
        ST_HOLD: state_d = hold_in ? ST_HOLD : ST_RUN;
        default: state_d = ST_OFF;
      endcase
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) state_q <= ST_OFF;
    else        state_q <= state_d;
  end

  // Writes and commits are dropped during the apply cycle.
  assign write_ok  = coef_wr_in && !busy_q;
  assign commit_ok = coef_commit_in && !busy_q;

  for (genvar gi = 0; gi < NUM_COEF; gi++) begin : g_we
    assign shadow_we[gi] = write_ok && (coef_sel_in == 3'(gi));
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      busy_q <= 1'b0;
      for (int i = 0; i < NUM_COEF; i++) begin
        shadow_q[i] <= '0;
        active_q[i] <= '0;
      end
    end else begin
      busy_q <= commit_ok;
      for (int i = 0; i < NUM_COEF; i++) begin
        if (shadow_we[i]) shadow_q[i] <= coef_data_in;
        if (commit_ok)    active_q[i] <= shadow_q[i];
      end
    end
  end

  iir1_stage #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .ANTI_WINDUP(1'b0)
  ) u_pd (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clr_i   (state_d == ST_OFF),
    .hold_i  (state_d == ST_HOLD),
    .a1_i    (active_q[COEF_A1_PD]),
    .b0_i    (active_q[COEF_B0_PD]),
    .b1_i    (active_q[COEF_B1_PD]),
    .x_i     (e_in),
    .lo_i    (D_MIN),
    .hi_i    (D_MAX),
    .railed_i(2'b00),
    .y_o     (pd_y),
    .sat_o   ()
  );

  iir1_stage #(
    .DATA_W(DATA_W), .COEF_W(COEF_W), .FRAC_W(FRAC_W), .ACC_W(ACC_W), .ANTI_WINDUP(1'b1)
  ) u_pi (
    .clk_in  (clk_in),
    .rst_in  (rst_in),
    .clr_i   (state_d == ST_OFF),
    .hold_i  (state_d == ST_HOLD),
    .a1_i    (active_q[COEF_A1_PI]),
    .b0_i    (active_q[COEF_B0_PI]),
    .b1_i    (active_q[COEF_B1_PI]),
    .x_i     (pd_y),
    .lo_i    (clamp_lo),
    .hi_i    (clamp_hi),
    .railed_i(railed_in),
    .y_o     (pi_y),
    .sat_o   (pi_sat)
  );

  assign e_out         = pi_y;
  assign sat_out       = pi_sat;
  assign state_out     = state_q;
  assign coef_busy_out = busy_q;

endmodule
